// File: rtl/sram_arb2_if.sv
// rtl/sram_arb2_if.sv - signal bundle joining two masters and the SRAM core to the arbiter
interface sram_arb2_if;
    logic        p0_req;
    logic        p0_ready;
    logic        p0_rd;
    logic [17:0] p0_addr;
    logic [1:0]  p0_be;
    logic [15:0] p0_wr_data;
    logic        p0_rd_data_vld;
    logic [15:0] p0_rd_data;
    logic        p1_req;
    logic        p1_ready;
    logic        p1_rd;
    logic [17:0] p1_addr;
    logic [1:0]  p1_be;
    logic [15:0] p1_wr_data;
    logic        p1_rd_data_vld;
    logic [15:0] p1_rd_data;
    logic        sram_req;
    logic        sram_ready;
    logic        sram_rd;
    logic [17:0] sram_addr;
    logic [1:0]  sram_be;
    logic [15:0] sram_wr_data;
    logic        sram_rd_data_vld;
    logic [15:0] sram_rd_data;
    logic        rd_orphan_err;

    modport master (
        input  p0_req, p0_rd, p0_addr, p0_be, p0_wr_data,
        output p0_ready, p0_rd_data_vld, p0_rd_data,
        input  p1_req, p1_rd, p1_addr, p1_be, p1_wr_data,
        output p1_ready, p1_rd_data_vld, p1_rd_data,
        output sram_req, sram_rd, sram_addr, sram_be, sram_wr_data,
        input  sram_ready, sram_rd_data_vld, sram_rd_data,
        output rd_orphan_err
    );

    modport slave (
        output p0_req, p0_rd, p0_addr, p0_be, p0_wr_data,
        input  p0_ready, p0_rd_data_vld, p0_rd_data,
        output p1_req, p1_rd, p1_addr, p1_be, p1_wr_data,
        input  p1_ready, p1_rd_data_vld, p1_rd_data,
        input  sram_req, sram_rd, sram_addr, sram_be, sram_wr_data,
        output sram_ready, sram_rd_data_vld, sram_rd_data,
        input  rd_orphan_err
    );
endinterface

// File: rtl/sram_arb2.sv
// rtl/sram_arb2.sv - two-port round-robin arbiter onto one SRAM core port with read-return tag FIFO
// Optional read-over-write tie priority: SRAM_ARB_RD_PRIORITY_EN
module sram_arb2 #(
    parameter int TAG_DEPTH_LOG2 = 2
) (
    input  logic         a_clk,
    input  logic         a_rst,
    sram_arb2_if.master  bus
);
    localparam int DEPTH = 1 << TAG_DEPTH_LOG2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state, state_nxt;
    logic                      owner, last, win, grant, hs;
    logic                      elig0, elig1, full, empty, push, pop, head;
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [TAG_DEPTH_LOG2:0]   count;
    logic                      tag_mem [DEPTH];
    logic                      sel_rd;
    logic [17:0]               sel_addr;
    logic [1:0]                sel_be;
    logic [15:0]               sel_data;

    // Eligibility uses the registered count, so a same-cycle pop never unblocks a read early
    assign full  = (count == (TAG_DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (count == '0);
    assign elig0 = bus.p0_req & (~bus.p0_rd | ~full);
    assign elig1 = bus.p1_req & (~bus.p1_rd | ~full);
    assign hs    = (state == BUSY) & bus.sram_ready;
    assign push  = hs & bus.sram_rd;
    assign pop   = bus.sram_rd_data_vld & ~empty;
    assign head  = tag_mem[rd_ptr];

    assign bus.p0_ready = hs & ~owner;
    assign bus.p1_ready = hs & owner;

    always_comb begin
        win = 1'b0;
        if (elig0 & elig1) begin
`ifdef SRAM_ARB_RD_PRIORITY_EN
            if (bus.p0_rd != bus.p1_rd) win = bus.p1_rd;
            else                        win = ~last;
`else
            win = ~last;
`endif
        end else begin
            win = elig1;
        end
    end

    always_comb begin
        sel_rd   = bus.p0_rd;
        sel_addr = bus.p0_addr;
        sel_be   = bus.p0_be;
        sel_data = bus.p0_wr_data;
        if (win) begin
            sel_rd   = bus.p1_rd;
            sel_addr = bus.p1_addr;
            sel_be   = bus.p1_be;
            sel_data = bus.p1_wr_data;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: if (elig0 | elig1) begin
                grant     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (bus.sram_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            bus.sram_req     <= 1'b0;
            bus.sram_rd      <= 1'b0;
            bus.sram_addr    <= '0;
            bus.sram_be      <= '0;
            bus.sram_wr_data <= '0;
            owner            <= 1'b0;
            last             <= 1'b1;
        end else if (grant) begin
            bus.sram_req     <= 1'b1;
            bus.sram_rd      <= sel_rd;
            bus.sram_addr    <= sel_addr;
            bus.sram_be      <= sel_rd ? 2'b11 : sel_be;
            bus.sram_wr_data <= sel_data;
            owner            <= win;
        end else if (hs) begin
            bus.sram_req     <= 1'b0;
            last             <= owner;
        end
    end

    always_ff @(posedge a_clk) begin
        if (push) tag_mem[wr_ptr] <= owner;
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Core returns data strictly in issue order, so the head tag names the destination port
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            bus.p0_rd_data_vld <= 1'b0;
            bus.p1_rd_data_vld <= 1'b0;
            bus.p0_rd_data     <= '0;
            bus.p1_rd_data     <= '0;
            bus.rd_orphan_err  <= 1'b0;
        end else begin
            bus.p0_rd_data_vld <= pop & ~head;
            bus.p1_rd_data_vld <= pop & head;
            if (pop & ~head) bus.p0_rd_data <= bus.sram_rd_data;
            if (pop & head)  bus.p1_rd_data <= bus.sram_rd_data;
            if (bus.sram_rd_data_vld & empty) bus.rd_orphan_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arb2.sv
// tb/tb_sram_arb2.sv - scoreboard bench for sram_arb2: directed masters, core model, decoupled monitor
module tb_sram_arb2;
    typedef struct {
        bit          rd;
        logic [17:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } cmd_t;
    typedef struct {
        int   port;
        cmd_t c;
    } exp_t;

    logic a_clk = 1'b0;
    logic a_rst = 1'b1;
    sram_arb2_if bus();

    sram_arb2 #(.TAG_DEPTH_LOG2(2)) dut (
        .a_clk (a_clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 a_clk = ~a_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int hs_last = -10;
    int rise_cyc = 0;
    int req_cyc0 = 0;
    int core_vld_cyc = -10;
    int ready_delay = 1;
    int ret_lat = 1;
    bit ret_en = 0;
    bit orphan_go = 0;
    bit acc0 = 0, acc1 = 0, req_prev = 0;
    cmd_t cmd0[$], cmd1[$];
    exp_t exp_q[$];
    logic [15:0] exp_rd0[$], exp_rd1[$], data_q[$];
    int ret_q[$], hs_q[$];
    cmd_t c0, c1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input bit rd, input logic [17:0] a, input logic [1:0] be, input logic [15:0] d);
        cmd_t c;
        c.rd = rd; c.addr = a; c.be = be; c.data = d;
        return c;
    endfunction

    task automatic send(input int p, input cmd_t c);
        if (p == 0) cmd0.push_back(c);
        else        cmd1.push_back(c);
    endtask

    task automatic expect_req(input int p, input cmd_t c);
        exp_t e;
        e.port = p;
        e.c = c;
        if (c.rd) e.c.be = 2'b11;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge a_clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || exp_rd0.size() > 0 || exp_rd1.size() > 0) && n < budget) begin
            step(1);
            n++;
        end
        check({name, "_timeout"}, n < budget, 1'b1);
    endtask

    task automatic do_reset();
        a_rst = 1'b1;
        cmd0.delete(); cmd1.delete(); exp_q.delete();
        exp_rd0.delete(); exp_rd1.delete(); data_q.delete(); ret_q.delete();
        step(3);
        a_rst = 1'b0;
    endtask

    always @(posedge a_clk) cyc <= cyc + 1;

    // Masters: present a command, hold until accepted, then present the next one
    always @(posedge a_clk) begin
        #1;
        if (a_rst) begin
            bus.p0_req = 0; bus.p0_rd = 0; bus.p0_addr = '0; bus.p0_be = '0; bus.p0_wr_data = '0;
        end else begin
            if (acc0) bus.p0_req = 1'b0;
            if (!bus.p0_req && cmd0.size() > 0) begin
                c0 = cmd0.pop_front();
                bus.p0_req = 1'b1; bus.p0_rd = c0.rd; bus.p0_addr = c0.addr;
                bus.p0_be = c0.be; bus.p0_wr_data = c0.data;
                req_cyc0 = cyc;
            end
        end
    end

    always @(posedge a_clk) begin
        #1;
        if (a_rst) begin
            bus.p1_req = 0; bus.p1_rd = 0; bus.p1_addr = '0; bus.p1_be = '0; bus.p1_wr_data = '0;
        end else begin
            if (acc1) bus.p1_req = 1'b0;
            if (!bus.p1_req && cmd1.size() > 0) begin
                c1 = cmd1.pop_front();
                bus.p1_req = 1'b1; bus.p1_rd = c1.rd; bus.p1_addr = c1.addr;
                bus.p1_be = c1.be; bus.p1_wr_data = c1.data;
            end
        end
    end

    // Core model: accepts after ready_delay cycles, returns read data ret_lat cycles after accept
    always @(posedge a_clk) begin
        #1;
        if (a_rst) begin
            bus.sram_ready = 1'b0; bus.sram_rd_data_vld = 1'b0; bus.sram_rd_data = '0;
        end else begin
            bus.sram_ready = bus.sram_req && (ready_delay == 0 || req_prev);
            if (orphan_go) begin
                bus.sram_rd_data_vld = 1'b1; bus.sram_rd_data = 16'hDEAD; orphan_go = 0;
            end else if (ret_en && ret_q.size() > 0 && data_q.size() > 0 && ret_q[0] + ret_lat <= cyc) begin
                bus.sram_rd_data_vld = 1'b1;
                bus.sram_rd_data = data_q.pop_front();
                void'(ret_q.pop_front());
            end else begin
                bus.sram_rd_data_vld = 1'b0;
            end
        end
    end

    always @(negedge a_clk) begin
        bit hs;
        exp_t e;
        acc0 = bus.p0_ready;
        acc1 = bus.p1_ready;
        if (!a_rst) begin
            if (bus.sram_req && !req_prev) rise_cyc = cyc;
            if (cyc == hs_last + 1) check("dead_cycle", bus.sram_req, 1'b0);
            hs = bus.sram_req && bus.sram_ready;
            if (bus.p0_ready || bus.p1_ready) check("ready_needs_hs", hs, 1'b1);
            if (hs) begin
                hs_cnt++; hs_last = cyc; hs_q.push_back(cyc);
                if (bus.sram_rd) ret_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_port", {bus.p1_ready, bus.p0_ready}, (e.port == 1) ? 2'b10 : 2'b01);
                    check("req_fields", {bus.sram_rd, bus.sram_addr, bus.sram_be, bus.sram_wr_data},
                          {e.c.rd, e.c.addr, e.c.be, e.c.data});
                end
            end
            if (bus.p0_rd_data_vld) begin
                if (exp_rd0.size() == 0) check("p0_unexpected_vld", 1'b1, 1'b0);
                else begin
                    check("p0_rd_data", bus.p0_rd_data, exp_rd0.pop_front());
                    check("p0_vld_latency", cyc - core_vld_cyc, 1);
                end
            end
            if (bus.p1_rd_data_vld) begin
                if (exp_rd1.size() == 0) check("p1_unexpected_vld", 1'b1, 1'b0);
                else begin
                    check("p1_rd_data", bus.p1_rd_data, exp_rd1.pop_front());
                    check("p1_vld_latency", cyc - core_vld_cyc, 1);
                end
            end
            if (bus.sram_rd_data_vld) core_vld_cyc = cyc;
        end
        req_prev = bus.sram_req;
    end

    initial begin
        cmd_t c;
        int n;
        do_reset();
        step(1);
        check("reset_req", bus.sram_req, 1'b0);
        check("reset_fields", {bus.sram_rd, bus.sram_addr, bus.sram_be, bus.sram_wr_data}, '0);
        check("reset_port_out", {bus.p0_ready, bus.p1_ready, bus.p0_rd_data_vld, bus.p1_rd_data_vld,
                                 bus.p0_rd_data, bus.p1_rd_data}, '0);
        check("reset_orphan", bus.rd_orphan_err, 1'b0);

        // Single write, core accepts one cycle after sram_req
        hs_q.delete();
        c = mk(0, 18'h00010, 2'b01, 16'hBEEF);
        send(0, c); expect_req(0, c);
        wait_drain("t1", 20);
        check("t1_req_latency", rise_cyc - req_cyc0, 1);
        check("t1_hs_after_req", hs_q[0] - rise_cyc, 1);
        orphan_go = 1;
        step(3);
        check("t1_write_no_tag", bus.rd_orphan_err, 1'b1);
        step(3);
        check("orphan_sticky", bus.rd_orphan_err, 1'b1);
        do_reset();
        step(1);
        check("orphan_cleared", bus.rd_orphan_err, 1'b0);

        // Both ports writing back to back: strict alternation with one dead cycle
        ready_delay = 0;
        hs_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(0, mk(0, 18'h20 + 18'(i), 2'b11, 16'h1000 + 16'(i)));
            send(1, mk(0, 18'h30 + 18'(i), 2'b10, 16'h2000 + 16'(i)));
            expect_req(0, mk(0, 18'h20 + 18'(i), 2'b11, 16'h1000 + 16'(i)));
            expect_req(1, mk(0, 18'h30 + 18'(i), 2'b10, 16'h2000 + 16'(i)));
        end
        wait_drain("t2", 40);
        for (int i = 0; i < 5; i++) check("t2_spacing", hs_q[i + 1] - hs_q[i], 2);

        // Four outstanding reads fill the tag FIFO; a fifth read waits while a write proceeds
        ret_en = 0; ret_lat = 1;
        for (int i = 0; i < 5; i++) send(0, mk(1, 18'h100 + 18'(i), 2'b00, 16'h0));
        for (int i = 0; i < 4; i++) expect_req(0, mk(1, 18'h100 + 18'(i), 2'b00, 16'h0));
        wait_drain("t3_fill", 40);
        c = mk(0, 18'h140, 2'b01, 16'h7777);
        send(1, c); expect_req(1, c);
        wait_drain("t3_write", 20);
        n = hs_cnt;
        step(6);
        check("t3_blocked_hs", hs_cnt, n);
        check("t3_blocked_req", bus.sram_req, 1'b0);
        data_q.push_back(16'h1234); exp_rd0.push_back(16'h1234);
        expect_req(0, mk(1, 18'h104, 2'b00, 16'h0));
        ret_en = 1;
        wait_drain("t3_unblock", 20);
        for (int i = 0; i < 4; i++) begin
            data_q.push_back(16'h3000 + 16'(i)); exp_rd0.push_back(16'h3000 + 16'(i));
        end
        wait_drain("t3_drain", 30);

        // Interleaved reads; first return coincides with the second read's push
        ret_lat = 2;
        c = mk(1, 18'h200, 2'b00, 16'h0);
        send(0, c); expect_req(0, c);
        step(1);
        c = mk(1, 18'h201, 2'b00, 16'h0);
        send(1, c); expect_req(1, c);
        data_q.push_back(16'hAAAA); data_q.push_back(16'h5555);
        exp_rd0.push_back(16'hAAAA); exp_rd1.push_back(16'h5555);
        wait_drain("t4", 30);
        step(2);
        orphan_go = 1;
        step(3);
        check("t4_fifo_empty_orphan", bus.rd_orphan_err, 1'b1);

        // Simultaneous p0 write and p1 read right after reset
        do_reset();
        c0 = mk(0, 18'h300, 2'b11, 16'h3333);
        c1 = mk(1, 18'h301, 2'b00, 16'h0);
        send(0, c0); send(1, c1);
`ifdef SRAM_ARB_RD_PRIORITY_EN
        expect_req(1, c1); expect_req(0, c0);
`else
        expect_req(0, c0); expect_req(1, c1);
`endif
        data_q.push_back(16'h4444); exp_rd1.push_back(16'h4444);
        wait_drain("t6", 30);
        check("t6_no_orphan", bus.rd_orphan_err, 1'b0);

        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
